id_ex_pipe_reg: RTL and testbench



---
 rtl/id_ex_pipe_reg.sv | 167 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall, flush and a per-slot valid bit.
// Define ID_EX_STATS_EN to add saturating bubble/stall counters with StatsClr.
module id_ex_pipe_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
`ifdef ID_EX_STATS_EN
    input  logic            StatsClr,
    output logic [31:0]     BubbleCnt,
    output logic [31:0]     StallCnt,
`endif
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic            ALUSrcAD,
    input  logic            SumSrcD,
    input  logic [2:0]      ResultSrcD,
    input  logic [3:0]      ALUControlD,
    input  logic [1:0]      StoreSrcD,
    input  logic [2:0]      TypeBranchD,
    input  logic [2:0]      LoadPartD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic            ALUSrcAE,
    output logic            SumSrcE,
    output logic [2:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [1:0]      StoreSrcE,
    output logic [2:0]      TypeBranchE,
    output logic [2:0]      LoadPartE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            ValidE
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alusrc;
        logic            alusrca;
        logic            sumsrc;
        logic [2:0]      resultsrc;
        logic [3:0]      alucontrol;
        logic [1:0]      storesrc;
        logic [2:0]      typebranch;
        logic [2:0]      loadpart;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] immext;
        logic [XLEN-1:0] pcplus4;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } slot_t;

    slot_t d_slot;
    slot_t e_q;
    logic  bubble;

    assign d_slot = '{
        valid:      1'b1,
        regwrite:   RegWriteD,
        memwrite:   MemWriteD,
        jump:       JumpD,
        branch:     BranchD,
        alusrc:     ALUSrcD,
        alusrca:    ALUSrcAD,
        sumsrc:     SumSrcD,
        resultsrc:  ResultSrcD,
        alucontrol: ALUControlD,
        storesrc:   StoreSrcD,
        typebranch: TypeBranchD,
        loadpart:   LoadPartD,
        rd1:        RD1D,
        rd2:        RD2D,
        pc:         PCD,
        immext:     ImmExtD,
        pcplus4:    PCPlus4D,
        rs1:        Rs1D,
        rs2:        Rs2D,
        rd:         RdD
    };

    // An invalid decode slot loads as an all-zero bubble so x control never reaches E.
    assign bubble = FlushE || (!StallE && !ValidD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= '0;
        end else if (bubble) begin
            e_q <= '0;
        end else if (!StallE) begin
            e_q <= d_slot;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.regwrite;
    assign MemWriteE   = e_q.memwrite;
    assign JumpE       = e_q.jump;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alusrc;
    assign ALUSrcAE    = e_q.alusrca;
    assign SumSrcE     = e_q.sumsrc;
    assign ResultSrcE  = e_q.resultsrc;
    assign ALUControlE = e_q.alucontrol;
    assign StoreSrcE   = e_q.storesrc;
    assign TypeBranchE = e_q.typebranch;
    assign LoadPartE   = e_q.loadpart;
    assign RD1E        = e_q.rd1;
    assign RD2E        = e_q.rd2;
    assign PCE         = e_q.pc;
    assign ImmExtE     = e_q.immext;
    assign PCPlus4E    = e_q.pcplus4;
    assign Rs1E        = e_q.rs1;
    assign Rs2E        = e_q.rs2;
    assign RdE         = e_q.rd;

`ifdef ID_EX_STATS_EN
    logic [31:0] bub_q;
    logic [31:0] stl_q;

    always_ff @(posedge clk) begin
        if (!rst_n || StatsClr) begin
            bub_q <= '0;
            stl_q <= '0;
        end else begin
            if (bubble && bub_q != 32'hFFFF_FFFF)
                bub_q <= bub_q + 32'd1;
            if (StallE && !FlushE && stl_q != 32'hFFFF_FFFF)
                stl_q <= stl_q + 32'd1;
        end
    end

    assign BubbleCnt = bub_q;
    assign StallCnt  = stl_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg against a field-table model.
module tb_id_ex_pipe_reg;

    localparam int NF = 20;
    localparam int W[NF] = '{1, 1, 1, 1, 1, 1, 1, 3, 4, 2,
                             3, 3, 32, 32, 32, 32, 32, 5, 5, 5};
    localparam string NM[NF] = '{"RegWrite", "MemWrite", "Jump",
        "Branch", "ALUSrc", "ALUSrcA", "SumSrc", "ResultSrc",
        "ALUControl", "StoreSrc", "TypeBranch", "LoadPart", "RD1",
        "RD2", "PC", "ImmExt", "PCPlus4", "Rs1", "Rs2", "Rd"};

    logic clk = 1'b0;
    logic rst_n, StallE, FlushE, ValidD, StatsClr;
    logic [31:0] d[NF];
    logic [31:0] e[NF];
    logic [31:0] m[NF];
    logic        mv;
    logic [31:0] mbub, mstl;
    int cmps = 0;
    int fails = 0;

    logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE;
    logic SumSrcE, ValidE;
    logic [2:0] ResultSrcE, TypeBranchE, LoadPartE;
    logic [3:0] ALUControlE;
    logic [1:0] StoreSrcE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [31:0] BubbleCnt, StallCnt;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD),
`ifdef ID_EX_STATS_EN
        .StatsClr(StatsClr), .BubbleCnt(BubbleCnt), .StallCnt(StallCnt),
`endif
        .RegWriteD(d[0][0]), .MemWriteD(d[1][0]), .JumpD(d[2][0]),
        .BranchD(d[3][0]), .ALUSrcD(d[4][0]), .ALUSrcAD(d[5][0]),
        .SumSrcD(d[6][0]), .ResultSrcD(d[7][2:0]),
        .ALUControlD(d[8][3:0]), .StoreSrcD(d[9][1:0]),
        .TypeBranchD(d[10][2:0]), .LoadPartD(d[11][2:0]),
        .RD1D(d[12]), .RD2D(d[13]), .PCD(d[14]), .ImmExtD(d[15]),
        .PCPlus4D(d[16]), .Rs1D(d[17][4:0]), .Rs2D(d[18][4:0]),
        .RdD(d[19][4:0]),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
        .SumSrcE(SumSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .StoreSrcE(StoreSrcE),
        .TypeBranchE(TypeBranchE), .LoadPartE(LoadPartE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE)
    );

`ifndef ID_EX_STATS_EN
    assign BubbleCnt = '0;
    assign StallCnt  = '0;
`endif

    assign e[0]  = {31'b0, RegWriteE};
    assign e[1]  = {31'b0, MemWriteE};
    assign e[2]  = {31'b0, JumpE};
    assign e[3]  = {31'b0, BranchE};
    assign e[4]  = {31'b0, ALUSrcE};
    assign e[5]  = {31'b0, ALUSrcAE};
    assign e[6]  = {31'b0, SumSrcE};
    assign e[7]  = {29'b0, ResultSrcE};
    assign e[8]  = {28'b0, ALUControlE};
    assign e[9]  = {30'b0, StoreSrcE};
    assign e[10] = {29'b0, TypeBranchE};
    assign e[11] = {29'b0, LoadPartE};
    assign e[12] = RD1E;
    assign e[13] = RD2E;
    assign e[14] = PCE;
    assign e[15] = ImmExtE;
    assign e[16] = PCPlus4E;
    assign e[17] = {27'b0, Rs1E};
    assign e[18] = {27'b0, Rs2E};
    assign e[19] = {27'b0, RdE};

    function automatic logic [31:0] mask(int i);
        return (W[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W[i]) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        cmps++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check();
        for (int i = 0; i < NF; i++) chk(NM[i], e[i], m[i]);
        chk("ValidE", {31'b0, ValidE}, {31'b0, mv});
        cmps++;
        assert (ValidE === 1'b1 ||
                {RegWriteE, MemWriteE, JumpE, BranchE} === 4'b0) else begin
            fails++;
            $error("FAIL gating got %b%b%b%b with ValidE %b exp 0000",
                   RegWriteE, MemWriteE, JumpE, BranchE, ValidE);
        end
`ifdef ID_EX_STATS_EN
        chk("BubbleCnt", BubbleCnt, mbub);
        chk("StallCnt", StallCnt, mstl);
`endif
    endtask

    task automatic clear_model();
        mv = 1'b0;
        for (int i = 0; i < NF; i++) m[i] = '0;
    endtask

    // Model advances from the inputs present just before the edge, then compares.
    task automatic tick();
        if (rst_n !== 1'b1) begin
            clear_model();
            mbub = '0;
            mstl = '0;
        end else begin
            if (StatsClr === 1'b1) begin
                mbub = '0;
                mstl = '0;
            end else begin
                if (FlushE || (!StallE && !ValidD)) mbub = sat_inc(mbub);
                if (StallE && !FlushE) mstl = sat_inc(mstl);
            end
            if (FlushE) clear_model();
            else if (StallE) begin end
            else if (ValidD === 1'b1) begin
                mv = 1'b1;
                for (int i = 0; i < NF; i++) m[i] = d[i] & mask(i);
            end else clear_model();
        end
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic zero_d();
        for (int i = 0; i < NF; i++) d[i] = '0;
    endtask

    initial begin
        clear_model();
        mbub = '0;
        mstl = '0;
        StatsClr = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        ValidD = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < NF; i++) d[i] = mask(i);
        #2;

        // reset with nonzero D, including reset mid-stall and mid-flush
        tick();
        StallE = 1'b1;
        FlushE = 1'b1;
        tick();

        // pass-through
        rst_n = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        zero_d();
        d[0] = 32'd1;
        d[8] = 32'd1;
        d[12] = 32'h0000_00AA;
        d[19] = 32'd7;
        tick();
        chk("pass_RD1E", RD1E, 32'h0000_00AA);
        chk("pass_RdE", {27'b0, RdE}, 32'd7);

        // stall hold
        d[14] = 32'h100;
        tick();
        d[14] = 32'h104;
        StallE = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_PCE", PCE, 32'h100);
        end
        StallE = 1'b0;
        tick();
        chk("release_PCE", PCE, 32'h104);

        // flush beats stall
        StallE = 1'b1;
        FlushE = 1'b1;
        d[1] = 32'd1;
        tick();
        chk("flush_ValidE", {31'b0, ValidE}, 32'd0);

        // invalid decode with undefined control
        StallE = 1'b0;
        FlushE = 1'b0;
        ValidD = 1'b0;
        d[0] = 'x;
        d[2] = 32'd1;
        d[3] = 32'd1;
        tick();
        chk("inv_RegWriteE", {31'b0, RegWriteE}, 32'd0);
        d[0] = 32'd1;
        ValidD = 1'b1;

`ifdef ID_EX_STATS_EN
        StatsClr = 1'b1;
        tick();
        StatsClr = 1'b0;
        FlushE = 1'b1;
        repeat (4) tick();
        FlushE = 1'b0;
        StallE = 1'b1;
        repeat (2) tick();
        StallE = 1'b0;
        ValidD = 1'b0;
        tick();
        ValidD = 1'b1;
        chk("bub5", BubbleCnt, 32'd5);
        chk("stl2", StallCnt, 32'd2);
        StatsClr = 1'b1;
        tick();
        StatsClr = 1'b0;
        chk("clr_bub", BubbleCnt, 32'd0);
        force dut.bub_q = 32'hFFFF_FFFF;
        #1;
        release dut.bub_q;
        mbub = 32'hFFFF_FFFF;
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        chk("sat_bub", BubbleCnt, 32'hFFFF_FFFF);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(99) >= 3);
            FlushE   = ($urandom_range(99) < 10);
            StallE   = ($urandom_range(99) < 25);
            ValidD   = ($urandom_range(99) < 80);
            StatsClr = ($urandom_range(99) < 3);
            for (int i = 0; i < NF; i++) d[i] = $urandom() & mask(i);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule
